// File: rtl/pix_sched.sv
// Slideshow picture scheduler: auto-advances every DWELL_FRAMES frames, takes
// next/prev/pause keys, and applies every picture change on a frame boundary.
module pix_sched #(
   parameter int unsigned PIX_CNT      = 11,
   parameter int unsigned DWELL_FRAMES = 300,
   parameter int unsigned FCNT_W       = 10
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       frame_start,
   input  logic       key_next,
   input  logic       key_prev,
   input  logic       key_pause,
   output logic [3:0] pix_num,
   output logic       pix_update,
   output logic       paused
);

   typedef enum logic {
      S_RUN,
      S_PAUSE
   } state_t;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_NEXT,
      REQ_PREV
   } req_t;

   localparam logic [3:0]        PIX_LAST   = 4'(PIX_CNT - 1);
   localparam logic [FCNT_W-1:0] DWELL_LAST = FCNT_W'(DWELL_FRAMES - 1);

   state_t            state_q, state_d;
   req_t              pend_q, pend_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [3:0]        pix_q, pix_d;
   logic              upd_q, upd_d;

   req_t              key_req;
   req_t              eff_req;
   logic [3:0]        pix_inc;
   logic [3:0]        pix_dec;

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         state_q <= S_RUN;
         pend_q  <= REQ_NONE;
         fcnt_q  <= '0;
         pix_q   <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         fcnt_q  <= fcnt_d;
         pix_q   <= pix_d;
         upd_q   <= upd_d;
      end
   end

   always_comb begin
      key_req = REQ_NONE;
      if (key_next) begin
         key_req = REQ_NEXT;
      end else if (key_prev) begin
         key_req = REQ_PREV;
      end

      eff_req = (key_req != REQ_NONE) ? key_req : pend_q;
      pix_inc = (pix_q >= PIX_LAST) ? '0 : pix_q + 4'd1;
      pix_dec = (pix_q == '0) ? PIX_LAST : pix_q - 4'd1;

      state_d = state_q;
      if (key_pause) begin
         state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
      end

      pend_d = pend_q;
      fcnt_d = fcnt_q;
      pix_d  = pix_q;

      // The frame decision uses state_q, so a coincident pause toggle only
      // affects later frames.
      if (frame_start) begin
         if (eff_req == REQ_NEXT) begin
            pix_d  = pix_inc;
            fcnt_d = '0;
            pend_d = REQ_NONE;
         end else if (eff_req == REQ_PREV) begin
            pix_d  = pix_dec;
            fcnt_d = '0;
            pend_d = REQ_NONE;
         end else if (state_q == S_RUN) begin
            if (fcnt_q == DWELL_LAST) begin
               pix_d  = pix_inc;
               fcnt_d = '0;
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
      end else if (key_req != REQ_NONE) begin
         pend_d = key_req;
      end

      upd_d = (pix_d != pix_q);
   end

   assign pix_num    = pix_q;
   assign pix_update = upd_q;
   assign paused     = (state_q == S_PAUSE);

endmodule

// File: tb/tb_pix_sched.sv
// Directed bench for pix_sched with PIX_CNT=3, DWELL_FRAMES=4.
module tb_pix_sched;

   logic       vga_clk;
   logic       sys_rst_n;
   logic       frame_start;
   logic       key_next;
   logic       key_prev;
   logic       key_pause;
   logic [3:0] pix_num;
   logic       pix_update;
   logic       paused;

   int unsigned n_cmp;
   int unsigned n_err;
   int unsigned upd_seen;

   pix_sched #(
      .PIX_CNT     (3),
      .DWELL_FRAMES(4),
      .FCNT_W      (10)
   ) dut (
      .vga_clk    (vga_clk),
      .sys_rst_n  (sys_rst_n),
      .frame_start(frame_start),
      .key_next   (key_next),
      .key_prev   (key_prev),
      .key_pause  (key_pause),
      .pix_num    (pix_num),
      .pix_update (pix_update),
      .paused     (paused)
   );

   initial begin
      vga_clk = 1'b0;
      forever #5 vga_clk = ~vga_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) @(negedge vga_clk);
   endtask

   // One-cycle key pulse with no frame_start.
   task automatic key(input logic nxt, input logic prv, input logic pse);
      key_next  = nxt;
      key_prev  = prv;
      key_pause = pse;
      @(negedge vga_clk);
      key_next  = 1'b0;
      key_prev  = 1'b0;
      key_pause = 1'b0;
   endtask

   // Frame pulse (any keys already driven are coincident with it), then check
   // the result in the next cycle and that pix_update drops one cycle later.
   task automatic frame(input string tag, input logic [3:0] exp_pix, input logic exp_upd);
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      key_next    = 1'b0;
      key_prev    = 1'b0;
      key_pause   = 1'b0;
      if (pix_update === 1'b1) upd_seen++;
      chk({tag, ".pix"}, 32'(pix_num), 32'(exp_pix));
      chk({tag, ".upd"}, 32'(pix_update), 32'(exp_upd));
      @(negedge vga_clk);
      chk({tag, ".upd_drop"}, 32'(pix_update), 32'd0);
      chk({tag, ".pix_hold"}, 32'(pix_num), 32'(exp_pix));
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      upd_seen    = 0;
      sys_rst_n   = 1'b0;
      frame_start = 1'b0;
      key_next    = 1'b0;
      key_prev    = 1'b0;
      key_pause   = 1'b0;
      idle(2);
      chk("rst.pix", 32'(pix_num), 32'd0);
      chk("rst.upd", 32'(pix_update), 32'd0);
      chk("rst.paused", 32'(paused), 32'd0);
      sys_rst_n = 1'b1;
      idle(1);

      // Auto run: advance after pulses 4, 8, 12
      upd_seen = 0;
      frame("auto1", 4'd0, 1'b0);
      frame("auto2", 4'd0, 1'b0);
      frame("auto3", 4'd0, 1'b0);
      frame("auto4", 4'd1, 1'b1);
      frame("auto5", 4'd1, 1'b0);
      frame("auto6", 4'd1, 1'b0);
      frame("auto7", 4'd1, 1'b0);
      frame("auto8", 4'd2, 1'b1);
      frame("auto9", 4'd2, 1'b0);
      frame("auto10", 4'd2, 1'b0);
      frame("auto11", 4'd2, 1'b0);
      frame("auto12", 4'd0, 1'b1);
      chk("auto.upd_count", 32'(upd_seen), 32'd3);

      // Manual deferral: key mid-frame, applied at next frame, fcnt restarts
      frame("defer.f1", 4'd0, 1'b0);
      idle(1);
      key(1'b1, 1'b0, 1'b0);
      idle(3);
      chk("defer.wait", 32'(pix_num), 32'd0);
      chk("defer.wait_upd", 32'(pix_update), 32'd0);
      frame("defer.apply", 4'd1, 1'b1);
      frame("defer.a1", 4'd1, 1'b0);
      frame("defer.a2", 4'd1, 1'b0);
      frame("defer.a3", 4'd1, 1'b0);
      frame("defer.a4", 4'd2, 1'b1);

      // Wrap and priority
      key(1'b1, 1'b0, 1'b0);
      frame("wrap.next", 4'd0, 1'b1);
      key(1'b0, 1'b1, 1'b0);
      idle(1);
      frame("wrap.prev", 4'd2, 1'b1);
      key(1'b1, 1'b1, 1'b0);
      frame("prio.both", 4'd0, 1'b1);
      key(1'b0, 1'b1, 1'b0);
      idle(2);
      key(1'b1, 1'b0, 1'b0);
      frame("prio.latest", 4'd1, 1'b1);
      frame("prio.nostep", 4'd1, 1'b0);

      // Pause: fcnt frozen, manual step still works and clears fcnt
      frame("pause.pre2", 4'd1, 1'b0);
      key(1'b0, 1'b0, 1'b1);
      chk("pause.on", 32'(paused), 32'd1);
      for (int unsigned i = 0; i < 10; i++) frame("pause.hold", 4'd1, 1'b0);
      chk("pause.still", 32'(paused), 32'd1);
      key(1'b1, 1'b0, 1'b0);
      frame("pause.next", 4'd2, 1'b1);
      key(1'b0, 1'b0, 1'b1);
      chk("pause.off", 32'(paused), 32'd0);
      frame("resume.f1", 4'd2, 1'b0);
      frame("resume.f2", 4'd2, 1'b0);
      frame("resume.f3", 4'd2, 1'b0);
      frame("resume.f4", 4'd0, 1'b1);

      // Coincidence: key_next with the dwell-completing frame -> single step
      frame("coin.f1", 4'd0, 1'b0);
      frame("coin.f2", 4'd0, 1'b0);
      frame("coin.f3", 4'd0, 1'b0);
      key_next = 1'b1;
      frame("coin.step", 4'd1, 1'b1);
      frame("coin.a1", 4'd1, 1'b0);
      frame("coin.a2", 4'd1, 1'b0);
      frame("coin.a3", 4'd1, 1'b0);
      frame("coin.a4", 4'd2, 1'b1);

      // Reset mid-operation with PAUSE and pending PREV
      key(1'b0, 1'b0, 1'b1);
      key(1'b0, 1'b1, 1'b0);
      chk("mrst.pre_paused", 32'(paused), 32'd1);
      chk("mrst.pre_pix", 32'(pix_num), 32'd2);
      sys_rst_n = 1'b0;
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      chk("mrst.pix", 32'(pix_num), 32'd0);
      chk("mrst.paused", 32'(paused), 32'd0);
      chk("mrst.upd", 32'(pix_update), 32'd0);
      frame("mrst.nostep", 4'd0, 1'b0);
      chk("mrst.run", 32'(paused), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
